vga_timing_gen: RTL and testbench

VGA raster timing generator running in the 25.175 MHz pixel-clock domain produced by the VGA PLL. It consumes the PLL's `outclk_0` as its clock and the PLL's `locked` as a run qualifier. It produces registered hsync/vsync, data-enable, pixel coordinates and frame/line strobes for the downstream pixel/colour path. Default timing is 640x480@60.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing defaults, sync polarities and FSM state type
// for the VGA timing path.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam bit          HSYNC_POL_DEF = 1'b0;
  localparam bit          VSYNC_POL_DEF = 1'b0;
  localparam int unsigned CNT_W_DEF     = 10;

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } vga_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running x/y counters qualified by PLL lock,
// with registered sync, data-enable, coordinate and strobe outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          HSYNC_POL = HSYNC_POL_DEF,
  parameter bit          VSYNC_POL = VSYNC_POL_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActEnd   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActEnd   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic       lock_s;
  logic       run_en;
  vga_state_t state_q, state_d;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  logic             hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
  logic [CNT_W-1:0] x_d, y_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s)  state_d = RUN;
      RUN:       if (!lock_s) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // Qualifying with lock_s makes a lost lock idle the outputs on the same edge as the state change.
  assign run_en = (state_q == RUN) && lock_s;

  // Output / datapath logic: counters and decoded outputs
  always_comb begin
    h_cnt_d       = '0;
    v_cnt_d       = '0;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
    x_d           = '0;
    y_d           = '0;
    if (run_en) begin
      if (h_cnt_q == HLast) begin
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
      de_d          = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
      hsync_d       = ((h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd)) ? VSYNC_POL : ~VSYNC_POL;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      running_d     = 1'b1;
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      running     <= running_d;
      x           <= x_d;
      y           <= y_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized lock-loss / async-reset bench for vga_timing_gen on a shrunken raster,
// scoreboarded against a frame-position reference model.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VA = 12, VF = 3, VS = 2, VB = 4;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam bit          HP = 1'b1;
  localparam bit          VP = 1'b0;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic hsync, vsync, de, line_start, frame_start, running;
  logic [CW-1:0] x, y;

  typedef struct packed {
    logic          run;
    logic          fs;
    logic          ls;
    logic          de;
    logic          vs;
    logic          hs;
    logic [CW-1:0] y;
    logic [CW-1:0] x;
  } obs_t;

  obs_t        cur;
  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  bit [2:0]    hist;
  bit          run_prev;
  bit          m_run;
  int unsigned t;
  int unsigned gap, kind, low_len;

  assign cur = {running, frame_start, line_start, de, vsync, hsync, y, x};

  vga_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HF),
    .H_SYNC    (HS),
    .H_BP      (HB),
    .V_ACTIVE  (VA),
    .V_FP      (VF),
    .V_SYNC    (VS),
    .V_BP      (VB),
    .HSYNC_POL (HP),
    .VSYNC_POL (VP),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running)
  );

  always #20 clk = ~clk;

  function automatic obs_t idle_obs();
    obs_t o;
    o    = '0;
    o.hs = ~HP;
    o.vs = ~VP;
    return o;
  endfunction

  // Expected outputs for the tt-th running clock since the last restart at (0,0).
  function automatic obs_t ref_obs(input int unsigned tt);
    obs_t        o;
    int unsigned idx, px, py;
    idx   = tt % FRAME;
    px    = idx % HT;
    py    = idx / HT;
    o.run = 1'b1;
    o.fs  = (idx == 0);
    o.ls  = (px == 0);
    o.de  = (px < HA) && (py < VA);
    o.hs  = (px >= HA + HF && px < HA + HF + HS) ? HP : ~HP;
    o.vs  = (py >= VA + VF && py < VA + VF + VS) ? VP : ~VP;
    o.x   = CW'(px);
    o.y   = CW'(py);
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got run=%0b fs=%0b ls=%0b de=%0b vs=%0b hs=%0b x=%0d y=%0d, expected run=%0b fs=%0b ls=%0b de=%0b vs=%0b hs=%0b x=%0d y=%0d",
               name, $time, act.run, act.fs, act.ls, act.de, act.vs, act.hs, act.x, act.y,
               expv.run, expv.fs, expv.ls, expv.de, expv.vs, expv.hs, expv.x, expv.y);
    end
  endtask

  // Reference model: outputs run once pll_locked has been seen high on the two edges
  // three and two clocks back (two sync stages plus the FSM), restarting at (0,0).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     = '0;
      run_prev = 1'b0;
      t        = 0;
      exp_q.delete();
    end else begin
      m_run = hist[2] && hist[1];
      hist  = {hist[1:0], pll_locked};
      if (m_run) begin
        t = run_prev ? t + 1 : 0;
        exp_q.push_back(ref_obs(t));
      end else begin
        exp_q.push_back(idle_obs());
      end
      run_prev = m_run;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("out", cur, exp_q.pop_front());
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset", cur, idle_obs());
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2 * FRAME + 40) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      gap  = $urandom_range(1, 2 * FRAME);
      kind = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (kind != 2) begin
        low_len = $urandom_range(1, 12);
        @(negedge clk);
        #3 pll_locked = 1'b0;
        repeat (low_len) @(posedge clk);
        @(negedge clk);
        #3 pll_locked = 1'b1;
      end else begin
        #7 rst = 1'b1;
        #1 check("async_rst", cur, idle_obs());
        #1 rst = 1'b0;
      end
    end

    repeat (2 * FRAME + 20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
